// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared core widths and scoreboard types for the writeback unit.
package writeback_unit_pkg;
    localparam int XLEN              = 32;
    localparam int REG_ADDR_WIDTH    = 5;
    localparam int WB_LSU_FIFO_DEPTH = 2;
    localparam int NUM_REGS          = 1 << REG_ADDR_WIDTH;
    typedef logic [1:0] pend_cnt_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: result, issue, hazard-query and register-file write signals of the writeback unit.
interface writeback_unit_if
    import writeback_unit_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int AW = REG_ADDR_WIDTH
);
    logic          i_Enable;
    logic          i_Alu_Valid;
    logic [AW-1:0] i_Alu_Addr;
    logic [XW-1:0] i_Alu_Data;
    logic          i_Lsu_Valid;
    logic          o_Lsu_Ready;
    logic [AW-1:0] i_Lsu_Addr;
    logic [XW-1:0] i_Lsu_Data;
    logic          i_Issue_Valid;
    logic [AW-1:0] i_Issue_Addr;
    logic [AW-1:0] i_Query_Addr_1;
    logic [AW-1:0] i_Query_Addr_2;
    logic          o_Hazard_1;
    logic          o_Hazard_2;
    logic          o_Write_Enable;
    logic [AW-1:0] o_Write_Addr;
    logic [XW-1:0] o_Write_Data;

    modport master (
        output i_Enable, i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        output i_Lsu_Valid, i_Lsu_Addr, i_Lsu_Data,
        output i_Issue_Valid, i_Issue_Addr, i_Query_Addr_1, i_Query_Addr_2,
        input  o_Lsu_Ready, o_Hazard_1, o_Hazard_2,
        input  o_Write_Enable, o_Write_Addr, o_Write_Data
    );

    modport slave (
        input  i_Enable, i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        input  i_Lsu_Valid, i_Lsu_Addr, i_Lsu_Data,
        input  i_Issue_Valid, i_Issue_Addr, i_Query_Addr_1, i_Query_Addr_2,
        output o_Lsu_Ready, o_Hazard_1, o_Hazard_2,
        output o_Write_Enable, o_Write_Addr, o_Write_Data
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with count-based full/empty; pointers wrap naturally at power-of-two depth.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and buffered LSU results onto the register-file write port
// and tracks outstanding loads per register for decode hazard detection.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN_P         = XLEN,
    parameter int AW             = REG_ADDR_WIDTH,
    parameter int LSU_FIFO_DEPTH = WB_LSU_FIFO_DEPTH
) (
    input  logic i_Clock,
    input  logic i_Reset,
    writeback_unit_if.slave wb
);
    localparam int NR = 1 << AW;

    logic [AW+XLEN_P-1:0] head;
    logic [AW-1:0]        head_addr;
    logic [XLEN_P-1:0]    head_data;
    logic                 fifo_full, fifo_empty, push, pop;
    logic                 sel_valid;
    logic [AW-1:0]        sel_addr;
    logic [XLEN_P-1:0]    sel_data;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [XLEN_P-1:0]    wdata_q, wdata_d;
    pend_cnt_t            cnt_q [NR];
    pend_cnt_t            cnt_d [NR];

    assign wb.o_Lsu_Ready = !i_Reset && wb.i_Enable && !fifo_full;
    assign push           = wb.i_Lsu_Valid && wb.o_Lsu_Ready;
    // ALU always has priority; the FIFO only drains on ALU-idle cycles
    assign pop            = wb.i_Enable && !wb.i_Alu_Valid && !fifo_empty;
    assign {head_addr, head_data} = head;

    wb_fifo #(
        .WIDTH(AW + XLEN_P),
        .DEPTH(LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_Clock),
        .rst    (i_Reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  ({wb.i_Lsu_Addr, wb.i_Lsu_Data}),
        .dout_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        sel_valid = wb.i_Enable && (wb.i_Alu_Valid || !fifo_empty);
        sel_addr  = wb.i_Alu_Valid ? wb.i_Alu_Addr : head_addr;
        sel_data  = wb.i_Alu_Valid ? wb.i_Alu_Data : head_data;
        we_d      = sel_valid && sel_addr != '0;
        waddr_d   = sel_valid ? sel_addr : waddr_q;
        wdata_d   = sel_valid ? sel_data : wdata_q;
    end

    // Decrement saturates so an LSU result without a recorded issue cannot wrap a count
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NR; r++) begin
            cnt_d[r] = cnt_q[r]
                + pend_cnt_t'(wb.i_Enable && wb.i_Issue_Valid && wb.i_Issue_Addr == AW'(r))
                - pend_cnt_t'(pop && head_addr == AW'(r) && cnt_q[r] != '0);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb.o_Write_Enable = we_q;
    assign wb.o_Write_Addr   = waddr_q;
    assign wb.o_Write_Data   = wdata_q;
    assign wb.o_Hazard_1     = cnt_q[wb.i_Query_Addr_1] != '0;
    assign wb.o_Hazard_2     = cnt_q[wb.i_Query_Addr_2] != '0;
endmodule
